ldtu_gain_sel_window: RTL and testbench

Parametrised successor to the LiTE-DTU input gain-selection/FIFO stage: a single-clock, non-TMR core that delays both gain streams and picks the output gain per sample. A retriggerable saturation window with configurable pre-depth and runtime-programmable post-length chooses gain 1 over gain 10. Adds valid gating, which the 160 MHz free-running stage lacks. Sits between baseline subtraction and the encoder; the TMR wrapper triplicates it as A/B/C.

---
 rtl/ldtu_gsel_pkg.sv | 23 ++
 rtl/ldtu_delay_line.sv | 31 +++
 rtl/ldtu_gain_sel_window.sv | 153 +++++++++++++++
 tb/tb_ldtu_gain_sel_window.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ldtu_gsel_pkg.sv
// Shared encodings and width helpers for the gain-selection window core.
package ldtu_gsel_pkg;

  // GAIN_SEL_MODE encodings; the reserved code behaves like auto.
  typedef enum logic [1:0] {
    MODE_AUTO = 2'b00,
    MODE_F10  = 2'b01,
    MODE_F01  = 2'b10,
    MODE_RSVD = 2'b11
  } gsel_mode_e;

  // Window counter must hold FIFO_DEPTH + 2^CNT_BITS - 1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned depth,
                                            input int unsigned cnt_bits);
    return $clog2(depth + (32'd1 << cnt_bits));
  endfunction

  // Position of the gain flag in the encoder word {gain_is_g01, sample}.
  function automatic int unsigned gain_flag_idx(input int unsigned nbits);
    return nbits;
  endfunction

endpackage

// File: rtl/ldtu_delay_line.sv
// Fixed-depth shift register; o_data is the entry that leaves on the next shift.
module ldtu_delay_line #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_shift,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_data
);

  logic [Width-1:0] r_mem [Depth];

  // Shift the whole line by one on every enabled cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_shift) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < Depth; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_data = r_mem[Depth-1];

endmodule

// File: rtl/ldtu_gain_sel_window.sv
// Gain-selection core: delays both gain streams by FIFO_DEPTH pushes and picks
// gain 1 for every sample inside a retriggerable saturation window.
module ldtu_gain_sel_window
  import ldtu_gsel_pkg::*;
#(
  parameter int unsigned NBITS      = 12,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_BITS   = 4,
  parameter int unsigned BSL_BITS   = 6
) (
  input  logic              CLK_A,
  input  logic              reset_A,
  input  logic [1:0]        GAIN_SEL_MODE,
  input  logic [CNT_BITS-1:0] WIN_POST,
  input  logic [NBITS-1:0]  SATURATION_value,
  input  logic              valid_in,
  input  logic [NBITS-1:0]  DATA_gain_10,
  input  logic [NBITS-1:0]  DATA_gain_01,
  output logic [NBITS:0]    DATA_to_enc,
  output logic              data_valid,
  output logic              baseline_flag,
  output logic              sat_seen
);

  localparam int unsigned CntW   = cnt_width(FIFO_DEPTH, CNT_BITS);
  localparam int unsigned FillW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GFlag  = gain_flag_idx(NBITS);

  gsel_mode_e         w_mode;
  logic               w_auto;
  logic               w_sat_in;
  logic               w_emit;
  logic               w_sel_g01;
  logic [NBITS-1:0]   w_old_g10;
  logic [NBITS-1:0]   w_old_g01;
  logic [NBITS-1:0]   w_sel_data;
  logic [NBITS:0]     w_word;
  logic               w_bsl;
  logic [CntW-1:0]    w_reload;
  logic [CntW-1:0]    w_cnt_d;
  logic [FillW-1:0]   w_fill_d;

  logic [CntW-1:0]    r_cnt;
  logic [FillW-1:0]   r_fill;
  logic [NBITS:0]     r_data;
  logic               r_valid;
  logic               r_bsl;
  logic               r_sat;

  ldtu_delay_line #(
    .Width (NBITS),
    .Depth (FIFO_DEPTH)
  ) u_dl_g10 (
    .i_clk   (CLK_A),
    .i_rst   (reset_A),
    .i_shift (valid_in),
    .i_data  (DATA_gain_10),
    .o_data  (w_old_g10)
  );

  ldtu_delay_line #(
    .Width (NBITS),
    .Depth (FIFO_DEPTH)
  ) u_dl_g01 (
    .i_clk   (CLK_A),
    .i_rst   (reset_A),
    .i_shift (valid_in),
    .i_data  (DATA_gain_01),
    .o_data  (w_old_g01)
  );

  assign w_mode   = gsel_mode_e'(GAIN_SEL_MODE);
  assign w_reload = CntW'(FIFO_DEPTH) + {{(CntW-CNT_BITS){1'b0}}, WIN_POST};

  // Mode decode, saturation detect and gain choice for the sample leaving the lines.
  always_comb begin
    w_auto    = 1'b0;
    w_sel_g01 = 1'b0;
    unique case (w_mode)
      MODE_F10: w_sel_g01 = 1'b0;
      MODE_F01: w_sel_g01 = 1'b1;
      default:  w_auto    = 1'b1;
    endcase
    w_sat_in = w_auto && valid_in && (DATA_gain_10 >= SATURATION_value);
    if (w_auto) begin
      // The counter value before this push's update still covers this sample.
      w_sel_g01 = w_sat_in || (r_cnt != '0);
    end
    w_sel_data = w_sel_g01 ? w_old_g01 : w_old_g10;
    w_word     = {w_sel_g01, w_sel_data};
    w_bsl      = !w_sel_g01 && (w_sel_data[NBITS-1:BSL_BITS] == '0);
    w_emit     = valid_in && (r_fill == FillW'(FIFO_DEPTH));
  end

  // Next-state for the window and fill counters; both only move on a push.
  always_comb begin
    w_cnt_d  = r_cnt;
    w_fill_d = r_fill;
    if (valid_in) begin
      if (!w_auto) begin
        w_cnt_d = '0;
      end else if (w_sat_in) begin
        w_cnt_d = w_reload;
      end else if (r_cnt != '0) begin
        w_cnt_d = r_cnt - CntW'(1);
      end
      if (r_fill != FillW'(FIFO_DEPTH)) begin
        w_fill_d = r_fill + FillW'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge CLK_A or posedge reset_A) begin
    if (reset_A) begin
      r_cnt  <= '0;
      r_fill <= '0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_fill <= w_fill_d;
    end
  end

  // Output register; word and baseline flag hold between emitted samples.
  always_ff @(posedge CLK_A or posedge reset_A) begin
    if (reset_A) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_bsl   <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_sat   <= w_sat_in;
      if (w_emit) begin
        r_data <= w_word;
        r_bsl  <= w_bsl;
      end
    end
  end

  assign DATA_to_enc   = r_data;
  assign data_valid    = r_valid;
  assign baseline_flag = r_bsl;
  assign sat_seen      = r_sat;

  // Baseline flag is defined for gain-10 words only.
  always_comb begin
    if (!reset_A && r_bsl) begin
      assert (r_data[GFlag] == 1'b0);
    end
  end

endmodule

// File: tb/tb_ldtu_gain_sel_window.sv
// Randomised bench with a push-indexed reference model plus directed literal checks.
module tb_ldtu_gain_sel_window;

  localparam int NB  = 12;
  localparam int D   = 8;
  localparam int CB  = 4;
  localparam int BSL = 6;
  localparam int HMAX = 8192;

  logic          CLK_A = 1'b0;
  logic          reset_A = 1'b1;
  logic [1:0]    GAIN_SEL_MODE = 2'b00;
  logic [CB-1:0] WIN_POST = '0;
  logic [NB-1:0] SATURATION_value = '1;
  logic          valid_in = 1'b0;
  logic [NB-1:0] DATA_gain_10 = '0;
  logic [NB-1:0] DATA_gain_01 = '0;
  logic [NB:0]   DATA_to_enc;
  logic          data_valid;
  logic          baseline_flag;
  logic          sat_seen;

  ldtu_gain_sel_window #(
    .NBITS      (NB),
    .FIFO_DEPTH (D),
    .CNT_BITS   (CB),
    .BSL_BITS   (BSL)
  ) dut (
    .CLK_A            (CLK_A),
    .reset_A          (reset_A),
    .GAIN_SEL_MODE    (GAIN_SEL_MODE),
    .WIN_POST         (WIN_POST),
    .SATURATION_value (SATURATION_value),
    .valid_in         (valid_in),
    .DATA_gain_10     (DATA_gain_10),
    .DATA_gain_01     (DATA_gain_01),
    .DATA_to_enc      (DATA_to_enc),
    .data_valid       (data_valid),
    .baseline_flag    (baseline_flag),
    .sat_seen         (sat_seen)
  );

  always #5 CLK_A = ~CLK_A;

  int n_total = 0;
  int n_pass  = 0;

  // Model: every sample pushed since reset, plus the most recent saturating push.
  logic [NB-1:0] h10 [HMAX];
  logic [NB-1:0] h01 [HMAX];
  int            n_push   = 0;
  int            last_sat = -1;
  int            last_wp  = 0;
  logic [NB:0]   e_word   = '0;
  logic          e_valid  = 1'b0;
  logic          e_bsl    = 1'b0;
  logic          e_sat    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    chk("data_valid", {31'd0, data_valid}, {31'd0, e_valid});
    chk("DATA_to_enc", {19'd0, DATA_to_enc}, {19'd0, e_word});
    chk("baseline_flag", {31'd0, baseline_flag}, {31'd0, e_bsl});
    chk("sat_seen", {31'd0, sat_seen}, {31'd0, e_sat});
  endtask

  // Apply one cycle of inputs, predict the registered outputs, then check them.
  task automatic cycle(input bit v, input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic [1:0] m, input logic [CB-1:0] wp,
                       input logic [NB-1:0] sat);
    bit auto_m;
    bit s_in;
    bit sel;
    logic [NB-1:0] smp;
    int k;
    valid_in = v; DATA_gain_10 = a; DATA_gain_01 = b;
    GAIN_SEL_MODE = m; WIN_POST = wp; SATURATION_value = sat;
    auto_m = (m == 2'b00) || (m == 2'b11);
    s_in   = auto_m && v && (a >= sat);
    e_sat  = s_in;
    e_valid = 1'b0;
    if (v) begin
      k = n_push;
      h10[k] = a;
      h01[k] = b;
      if (k >= D) begin
        if (m == 2'b01)      sel = 1'b0;
        else if (m == 2'b10) sel = 1'b1;
        else sel = s_in || (last_sat >= 0 && (k - last_sat) <= D + last_wp);
        smp = sel ? h01[k-D] : h10[k-D];
        e_word  = {sel, smp};
        e_bsl   = !sel && ((smp >> BSL) == 0);
        e_valid = 1'b1;
      end
      if (!auto_m) last_sat = -1;
      else if (s_in) begin
        last_sat = k;
        last_wp  = int'(wp);
      end
      n_push++;
    end
    @(posedge CLK_A);
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset_A = 1'b1;
    valid_in = 1'b0;
    n_push = 0; last_sat = -1; last_wp = 0;
    e_word = '0; e_valid = 1'b0; e_bsl = 1'b0; e_sat = 1'b0;
    #1;
    compare();
    @(posedge CLK_A);
    #1;
    reset_A = 1'b0;
  endtask

  logic [1:0]    r_mode;
  logic [NB-1:0] r_satv;
  logic [NB-1:0] a;
  int            rr;

  initial begin
    @(posedge CLK_A);
    #1;
    do_reset();

    // Fill and window with a ramp; saturation at push 20, WIN_POST=4.
    for (int k = 0; k <= 34; k++) begin
      a = (k == 20) ? 12'hFFF : NB'(k + 1);
      cycle(1'b1, a, NB'(12'h100 + k), 2'b00, 4'd4, 12'hFFF);
      if (k == 7)  chk("lit_fill_quiet", {31'd0, data_valid}, 32'd0);
      if (k == 8) begin
        chk("lit_first_word", {19'd0, DATA_to_enc}, 32'h0001);
        chk("lit_first_bsl", {31'd0, baseline_flag}, 32'd1);
      end
      if (k == 19) chk("lit_pre_window", {19'd0, DATA_to_enc}, 32'h000C);
      if (k == 20) begin
        chk("lit_window_start", {19'd0, DATA_to_enc}, 32'h110C);
        chk("lit_sat_pulse", {31'd0, sat_seen}, 32'd1);
      end
      if (k == 21) chk("lit_sat_once", {31'd0, sat_seen}, 32'd0);
      if (k == 32) chk("lit_window_end", {19'd0, DATA_to_enc}, 32'h1118);
      if (k == 33) chk("lit_post_window", {19'd0, DATA_to_enc}, 32'h001A);
    end

    // Forced gain 1 with zero gain-10 data.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 12'h000, 12'h055, 2'b10, 4'd4, 12'hFFF);
    end
    chk("lit_force_g01", {19'd0, DATA_to_enc}, 32'h1055);
    chk("lit_force_bsl", {31'd0, baseline_flag}, 32'd0);

    // Open a window in auto, then force gain 10 mid-window and return to auto.
    cycle(1'b1, 12'hFFF, 12'h077, 2'b00, 4'd15, 12'hFFF);
    chk("lit_auto_win", {31'd0, DATA_to_enc[NB]}, 32'd1);
    cycle(1'b1, 12'h003, 12'h077, 2'b01, 4'd15, 12'hFFF);
    chk("lit_force_g10", {31'd0, DATA_to_enc[NB]}, 32'd0);
    cycle(1'b1, 12'h003, 12'h077, 2'b00, 4'd15, 12'hFFF);
    chk("lit_cnt_cleared", {31'd0, DATA_to_enc[NB]}, 32'd0);

    // Reset in the middle of a window.
    cycle(1'b1, 12'hFFF, 12'h077, 2'b00, 4'd4, 12'hFFF);
    cycle(1'b1, 12'h010, 12'h077, 2'b00, 4'd4, 12'hFFF);
    do_reset();
    chk("lit_reset_word", {19'd0, DATA_to_enc}, 32'd0);
    for (int k = 0; k < 9; k++) begin
      cycle(1'b1, NB'(k + 2), 12'h0AA, 2'b00, 4'd4, 12'hFFF);
      if (k == 7) chk("lit_refill_quiet", {31'd0, data_valid}, 32'd0);
    end
    chk("lit_refill_word", {19'd0, DATA_to_enc}, 32'h0002);

    // Randomised traffic against the model.
    r_mode = 2'b00;
    r_satv = 12'hF00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) begin
        rr = int'($urandom_range(0, 9));
        r_mode = (rr < 6) ? 2'b00 : (rr == 6) ? 2'b11 : (rr < 9) ? 2'b10 : 2'b01;
      end
      if ($urandom_range(0, 99) < 2) r_satv = NB'($urandom_range(12'h800, 12'hFFF));
      rr = int'($urandom_range(0, 99));
      if (rr < 6)       a = NB'($urandom_range(12'hF80, 12'hFFF));
      else if (rr < 45) a = NB'($urandom_range(0, 127));
      else              a = NB'($urandom_range(0, 4095));
      cycle($urandom_range(0, 9) < 7, a, NB'($urandom_range(0, 4095)), r_mode,
            CB'($urandom_range(0, 15)), r_satv);
      if ($urandom_range(0, 999) < 3) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
